cache_sa: RTL

Parametrised N-way set-associative, write-back, write-allocate data cache between the MA stage and the DDR controller. It generalises the direct-mapped single-line cache in width, line size, set count and associativity, and adds two behaviours: pseudo-LRU victim selection, and queuing of a read that arrives in the same cycle as a write. The MA side sees single-word accesses. The DDR side sees whole-line reads and writes with an enable/fin handshake.

---
 rtl/cache_sa.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_sa.sv
// cache_sa: N-way set-associative write-back, write-allocate data cache.
// Ports: clk/rst, MA word read/write (en/fin), DDR line read/write (en/fin).
module cache_sa #(
  parameter int ADDR_W  = 27,
  parameter int WORD_W  = 32,
  parameter int LINE_W  = 128,
  parameter int INDEX_W = 12,
  parameter int WAYS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] MA2cache_rd_addr,
  input  logic              MA2cache_rd_en,
  output logic              cache2MA_rd_fin,
  output logic [WORD_W-1:0] cache2MA_rd_data,
  input  logic [ADDR_W-1:0] MA2cache_wr_addr,
  input  logic [WORD_W-1:0] MA2cache_wr_data,
  input  logic              MA2cache_wr_en,
  output logic              cache2MA_wr_fin,
  output logic [ADDR_W-1:0] cache2DDR_rd_addr,
  output logic              cache2DDR_rd_en,
  input  logic              DDR2cache_rd_fin,
  input  logic [LINE_W-1:0] DDR2cache_rd_data,
  output logic [ADDR_W-1:0] cache2DDR_wr_addr,
  output logic [LINE_W-1:0] cache2DDR_wr_data,
  output logic              cache2DDR_wr_en,
  input  logic              DDR2cache_wr_fin
);

  localparam int OFF_W = $clog2(LINE_W / WORD_W);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int SETS  = 1 << INDEX_W;
  localparam int SH    = $clog2(WORD_W);
  localparam int LOW_W = OFF_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  state_t state_q, state_d;

  // Per-set state. The pLRU tree is held in 3 bits; only the low
  // WAYS-1 of them are ever written.
  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0]             dirty_q [SETS];
  logic [2:0]                  plru_q  [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
  logic [WAYS-1:0][LINE_W-1:0] data_q  [SETS];

  logic              req_wr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [WORD_W-1:0] req_wdata_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [1:0]        victim_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-1:0]   off;

  assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
  assign idx     = req_addr_q[LOW_W +: INDEX_W];
  assign off     = req_addr_q[2 +: OFF_W];

  logic unused_low;
  assign unused_low = ^req_addr_q[1:0];

  function automatic logic [WORD_W-1:0] get_word(
    input logic [LINE_W-1:0] l,
    input logic [OFF_W-1:0]  o
  );
    return l[{o, {SH{1'b0}}} +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(
    input logic [LINE_W-1:0] l,
    input logic [OFF_W-1:0]  o,
    input logic [WORD_W-1:0] w
  );
    logic [LINE_W-1:0] r;
    r = l;
    r[{o, {SH{1'b0}}} +: WORD_W] = w;
    return r;
  endfunction

  function automatic logic [WAYS-1:0] way_oh(input logic [1:0] w);
    logic [WAYS-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++) r[i] = (2'(i) == w);
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] pick_line(
    input logic [WAYS-1:0][LINE_W-1:0] s,
    input logic [1:0]                  w
  );
    logic [LINE_W-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++)
      if (2'(i) == w) r = s[i];
    return r;
  endfunction

  function automatic logic [TAG_W-1:0] pick_tag(
    input logic [WAYS-1:0][TAG_W-1:0] s,
    input logic [1:0]                 w
  );
    logic [TAG_W-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++)
      if (2'(i) == w) r = s[i];
    return r;
  endfunction

  // Tree pLRU: bit 0 is the root (0 = left half is LRU), bit 1 the
  // ways 0/1 node, bit 2 the ways 2/3 node. Each bit names the LRU side.
  function automatic logic [1:0] plru_victim(input logic [2:0] t);
    logic [1:0] r;
    r = 2'b00;
    if (WAYS == 4)
      r = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
    else if (WAYS == 2)
      r = {1'b0, t[0]};
    return r;
  endfunction

  function automatic logic [2:0] plru_touch(
    input logic [2:0] t,
    input logic [1:0] w
  );
    logic [2:0] r;
    r = t;
    if (WAYS == 4) begin
      r[0] = ~w[1];
      if (w[1]) r[2] = ~w[0];
      else      r[1] = ~w[0];
    end else if (WAYS == 2) begin
      r[0] = ~w[0];
    end
    return r;
  endfunction

  logic [WAYS-1:0]             s_valid;
  logic [WAYS-1:0]             s_dirty;
  logic [2:0]                  s_plru;
  logic [WAYS-1:0][TAG_W-1:0]  s_tag;
  logic [WAYS-1:0][LINE_W-1:0] s_data;

  assign s_valid = valid_q[idx];
  assign s_dirty = dirty_q[idx];
  assign s_plru  = plru_q[idx];
  assign s_tag   = tag_q[idx];
  assign s_data  = data_q[idx];

  logic              hit;
  logic [1:0]        hit_way;
  logic              inv_found;
  logic [1:0]        inv_way;
  logic [1:0]        victim;
  logic              vic_dirty;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] fill_line;
  logic              wb_acc;
  logic              fill_acc;

  always_comb begin
    hit       = 1'b0;
    hit_way   = 2'b00;
    inv_found = 1'b0;
    inv_way   = 2'b00;
    for (int i = 0; i < WAYS; i++) begin
      if (!hit && s_valid[i] && s_tag[i] == req_tag) begin
        hit     = 1'b1;
        hit_way = 2'(i);
      end
      if (!inv_found && !s_valid[i]) begin
        inv_found = 1'b1;
        inv_way   = 2'(i);
      end
    end
    victim    = inv_found ? inv_way : plru_victim(s_plru);
    vic_dirty = |(way_oh(victim) & s_valid & s_dirty);
  end

  assign hit_line  = pick_line(s_data, hit_way);
  assign fill_line = req_wr_q
    ? put_word(DDR2cache_rd_data, off, req_wdata_q)
    : DDR2cache_rd_data;
  assign wb_acc   = (state_q == WB) && cache2DDR_wr_en && DDR2cache_wr_fin;
  assign fill_acc = (state_q == FILL) && cache2DDR_rd_en && DDR2cache_rd_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (MA2cache_wr_en || MA2cache_rd_en) state_d = LOOKUP;
      LOOKUP:
        if (hit)            state_d = RESP;
        else if (vic_dirty) state_d = WB;
        else                state_d = FILL;
      WB:
        if (wb_acc) state_d = FILL;
      FILL:
        if (fill_acc) state_d = RESP;
      RESP:
        state_d = pend_q ? LOOKUP : IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr_q          <= 1'b0;
      req_addr_q        <= '0;
      req_wdata_q       <= '0;
      pend_q            <= 1'b0;
      pend_addr_q       <= '0;
      victim_q          <= 2'b00;
      cache2MA_rd_fin   <= 1'b0;
      cache2MA_rd_data  <= '0;
      cache2MA_wr_fin   <= 1'b0;
      cache2DDR_rd_addr <= '0;
      cache2DDR_rd_en   <= 1'b0;
      cache2DDR_wr_addr <= '0;
      cache2DDR_wr_data <= '0;
      cache2DDR_wr_en   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      cache2MA_rd_fin <= 1'b0;
      cache2MA_wr_fin <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A simultaneous write goes first; the read waits in pend.
          if (MA2cache_wr_en) begin
            req_wr_q    <= 1'b1;
            req_addr_q  <= MA2cache_wr_addr;
            req_wdata_q <= MA2cache_wr_data;
            pend_q      <= MA2cache_rd_en;
            pend_addr_q <= MA2cache_rd_addr;
          end else if (MA2cache_rd_en) begin
            req_wr_q   <= 1'b0;
            req_addr_q <= MA2cache_rd_addr;
          end
        end
        LOOKUP: begin
          if (hit) begin
            plru_q[idx] <= plru_touch(s_plru, hit_way);
            if (req_wr_q) begin
              dirty_q[idx]    <= s_dirty | way_oh(hit_way);
              cache2MA_wr_fin <= 1'b1;
            end else begin
              cache2MA_rd_fin  <= 1'b1;
              cache2MA_rd_data <= get_word(hit_line, off);
            end
          end else begin
            victim_q <= victim;
            if (vic_dirty) begin
              cache2DDR_wr_en   <= 1'b1;
              cache2DDR_wr_addr <= {pick_tag(s_tag, victim), idx,
                                    {LOW_W{1'b0}}};
              cache2DDR_wr_data <= pick_line(s_data, victim);
            end else begin
              cache2DDR_rd_en   <= 1'b1;
              cache2DDR_rd_addr <= {req_tag, idx, {LOW_W{1'b0}}};
            end
          end
        end
        WB: begin
          if (wb_acc) begin
            cache2DDR_wr_en   <= 1'b0;
            cache2DDR_rd_en   <= 1'b1;
            cache2DDR_rd_addr <= {req_tag, idx, {LOW_W{1'b0}}};
          end
        end
        FILL: begin
          if (fill_acc) begin
            cache2DDR_rd_en <= 1'b0;
            valid_q[idx]    <= s_valid | way_oh(victim_q);
            plru_q[idx]     <= plru_touch(s_plru, victim_q);
            if (req_wr_q) begin
              dirty_q[idx]    <= s_dirty | way_oh(victim_q);
              cache2MA_wr_fin <= 1'b1;
            end else begin
              dirty_q[idx]     <= s_dirty & ~way_oh(victim_q);
              cache2MA_rd_fin  <= 1'b1;
              cache2MA_rd_data <= get_word(DDR2cache_rd_data, off);
            end
          end
        end
        RESP: begin
          if (pend_q) begin
            req_wr_q   <= 1'b0;
            req_addr_q <= pend_addr_q;
            pend_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and line storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && req_wr_q) begin
      for (int i = 0; i < WAYS; i++)
        if (2'(i) == hit_way)
          data_q[idx][i] <= put_word(hit_line, off, req_wdata_q);
    end
    if (fill_acc) begin
      for (int i = 0; i < WAYS; i++)
        if (2'(i) == victim_q) begin
          data_q[idx][i] <= fill_line;
          tag_q[idx][i]  <= req_tag;
        end
    end
  end

endmodule
